// File: rtl/reg_pipe.sv
// reg_pipe -- elastic register pipeline with per-stage valid bits.
//
// A chain of DEPTH registered stages. Readiness ripples back from the output
// combinationally, so words advance into any empty downstream slot (bubbles
// collapse). A full pipe still moves one word per cycle when the consumer
// is ready.
//
// Parameters
//   WIDTH  data bits per word
//   DEPTH  number of register stages (1..16)
// Ports
//   clk        single clock, rising edge
//   clear      asynchronous active-high reset; empties the pipe and zeroes data
//   flush      synchronous discard of all held words; data registers hold
//   in_valid   producer offers in_data
//   in_ready   block accepts in_data this cycle
//   in_data    input word
//   out_valid  out_data holds a valid word (last stage valid bit)
//   out_ready  consumer takes out_data this cycle
//   out_data   word held in the last stage
//   count      number of valid stages (registered)
module reg_pipe #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [DEPTH-1:0] ready;
  logic             in_xfer;
  logic             out_xfer;
  logic [CW-1:0]    count_reg;

  // A stage may load when it is empty or its occupant is moving on.
  always_comb begin
    ready = '0;
    ready[DEPTH-1] = !stage_valid[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      ready[i] = !stage_valid[i] | ready[i+1];
    end
  end

  // Clear is folded in so no input is accepted while the block is held.
  assign in_ready  = ready[0] & !flush & !clear;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = stage_valid[DEPTH-1] & out_ready;
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];
  assign count     = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             valid_reg;
      logic [WIDTH-1:0] data_reg;
      logic             load_valid;
      logic [WIDTH-1:0] load_data;

      if (gi == 0) begin : g_head
        assign load_valid = in_xfer;
        assign load_data  = in_data;
      end else begin : g_body
        assign load_valid = stage_valid[gi-1];
        assign load_data  = stage_data[gi-1];
      end

      // The data register is written only when a real word arrives, so a
      // stage that drains keeps showing the last word it held.
      always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (ready[gi]) begin
          valid_reg <= load_valid;
          if (load_valid) begin
            data_reg <= load_data;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_data[gi]  = data_reg;
    end
  endgenerate

  // Occupancy tracks transfers; a pop during flush is still a delivery, but
  // flush empties the pipe regardless.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      count_reg <= '0;
    end else if (flush) begin
      count_reg <= '0;
    end else begin
      case ({in_xfer, out_xfer})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe -- randomized bench for reg_pipe. Two instances (DEPTH=4 and
// DEPTH=1) share the stimulus. A slot-occupancy reference model predicts
// in_ready/out_valid/out_data/count each cycle; a scoreboard queue per
// instance holds accepted words, popped by a separate output monitor.
module tb_reg_pipe;
  localparam int W = 24;

  logic         clk = 1'b0;
  logic         clear;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] in_data;

  logic         in_ready4, out_valid4;
  logic [W-1:0] out_data4;
  logic [2:0]   count4;
  logic         in_ready1, out_valid1;
  logic [W-1:0] out_data1;
  logic [0:0]   count1;

  always #5 clk = ~clk;

  reg_pipe #(.WIDTH(W), .DEPTH(4)) dut4 (
    .clk(clk), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .count(count4)
  );

  reg_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .count(count1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each held word has a slot position 0..d-1, oldest first.
  int           mdepth [2] = '{4, 1};
  int           mn     [2];
  int           mpos   [2][16];
  logic [W-1:0] mdata  [2][16];
  logic [W-1:0] mlast  [2];

  logic [W-1:0] sb0 [$];
  logic [W-1:0] sb1 [$];
  bit           pend      [2];
  logic [W-1:0] pend_data [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mn[k] = 0;
      mlast[k] = '0;
      pend[k] = 1'b0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  // Compare the DUT against the model for the current cycle, then advance
  // the model across the coming edge.
  task automatic model_cycle(int k);
    int d, first, lim, n2;
    int np [16];
    bit at_end, popped, irdy;
    logic         a_ir, a_ov;
    logic [W-1:0] a_od;
    logic [31:0]  a_cnt;
    string        tag;
    d = mdepth[k];
    at_end = (mn[k] > 0) && (mpos[k][0] == d - 1);
    popped = at_end && out_ready;
    first = popped ? 1 : 0;
    lim = d;
    // Each word moves one slot forward unless blocked by the word ahead.
    for (int j = first; j < mn[k]; j++) begin
      np[j] = (mpos[k][j] + 1 < lim - 1) ? mpos[k][j] + 1 : lim - 1;
      lim = np[j];
    end
    irdy = !clear && !flush && (lim >= 1);

    a_ir  = (k == 0) ? in_ready4  : in_ready1;
    a_ov  = (k == 0) ? out_valid4 : out_valid1;
    a_od  = (k == 0) ? out_data4  : out_data1;
    a_cnt = (k == 0) ? 32'(count4) : 32'(count1);
    tag   = (k == 0) ? "d4" : "d1";
    check({tag, " in_ready"},  32'(a_ir), 32'(irdy));
    check({tag, " out_valid"}, 32'(a_ov), 32'(at_end));
    check({tag, " out_data"},  32'(a_od), 32'(at_end ? mdata[k][0] : mlast[k]));
    check({tag, " count"},     a_cnt,     32'(mn[k]));

    if (at_end) mlast[k] = mdata[k][0];
    pend[k] = 1'b0;
    if (clear) return;
    if (flush) begin
      mn[k] = 0;
      return;
    end
    n2 = 0;
    for (int j = first; j < mn[k]; j++) begin
      mpos[k][n2]  = np[j];
      mdata[k][n2] = mdata[k][j];
      n2++;
    end
    if (in_valid && irdy) begin
      mpos[k][n2]  = 0;
      mdata[k][n2] = in_data;
      n2++;
      pend[k] = 1'b1;
      pend_data[k] = in_data;
    end
    mn[k] = n2;
    if (mn[k] > 0 && mpos[k][0] == d - 1) mlast[k] = mdata[k][0];
  endtask

  // Output monitor: every output transfer must match the oldest accepted word.
  always @(negedge clk) begin
    if (out_valid4 && out_ready) begin
      if (sb0.size() == 0) check("d4 sb_empty_pop", 32'(out_data4), 32'hDEAD_BEEF);
      else check("d4 order", 32'(out_data4), 32'(sb0.pop_front()));
    end
    if (out_valid1 && out_ready) begin
      if (sb1.size() == 0) check("d1 sb_empty_pop", 32'(out_data1), 32'hDEAD_BEEF);
      else check("d1 order", 32'(out_data1), 32'(sb1.pop_front()));
    end
  end

  task automatic run_phase(int cycles, int piv, int por, int pflush, int pclear,
                           bit force_clear_last);
    bit do_clear;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      // Account for the edge just taken: flush discards, then the accepted word.
      if (flush) begin
        sb0.delete();
        sb1.delete();
      end
      if (pend[0]) sb0.push_back(pend_data[0]);
      if (pend[1]) sb1.push_back(pend_data[1]);
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      #1;
      clear     = 1'b0;
      in_valid  = ($urandom_range(99) < piv);
      out_ready = ($urandom_range(99) < por);
      in_data   = W'($urandom);
      do_clear  = ($urandom_range(999) < pclear) || (force_clear_last && c == cycles - 1);
      flush     = !do_clear && ($urandom_range(99) < pflush);
      if (do_clear) begin
        #2 clear = 1'b1;
        #1;
        check("async out_valid4", 32'(out_valid4), 32'd0);
        check("async count4",     32'(count4),     32'd0);
        check("async out_data4",  32'(out_data4),  32'd0);
        check("async in_ready4",  32'(in_ready4),  32'd0);
        check("async out_data1",  32'(out_data1),  32'd0);
        model_reset();
      end
      @(negedge clk);
      model_cycle(0);
      model_cycle(1);
    end
  endtask

  initial begin
    clear = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    model_reset();
    #12;
    check("reset out_valid4", 32'(out_valid4), 32'd0);
    check("reset count4",     32'(count4),     32'd0);
    check("reset in_ready4",  32'(in_ready4),  32'd0);
    check("reset out_data1",  32'(out_data1),  32'd0);

    run_phase(300, 50, 50,  3, 5, 1'b0);  // mixed traffic
    run_phase(200, 90, 15,  2, 0, 1'b1);  // backpressure fill, clear while full
    run_phase(200, 100, 100, 0, 0, 1'b0); // continuous throughput
    run_phase(200, 25, 90,  4, 5, 1'b0);  // sparse input, bubbles
    run_phase(200, 70, 60,  8, 3, 1'b0);  // frequent flush
    run_phase(30,  0, 100,  0, 0, 1'b0);  // drain

    @(posedge clk);
    if (pend[0]) sb0.push_back(pend_data[0]);
    if (pend[1]) sb1.push_back(pend_data[1]);
    check("d4 drained", 32'(sb0.size()), 32'd0);
    check("d1 drained", 32'(sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
